// File: rtl/pel_frame_source.sv
// Raster-frame stimulus source: size token then N*N pels per frame.
// Both outputs follow the data/wr/full FIFO write convention.
module pel_frame_source #(
  parameter int DATA_W   = 8,
  parameter int SIZE_W   = 6,
  parameter int FRAMES_W = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [SIZE_W-1:0]   cfg_size,
  input  logic [FRAMES_W-1:0] cfg_frames,
  input  logic [DATA_W-1:0]   cfg_seed,
  output logic [SIZE_W-1:0]   out_size_data,
  output logic                out_size_wr,
  input  logic                out_size_full,
  output logic [DATA_W-1:0]   out_pel_data,
  output logic                out_pel_wr,
  input  logic                out_pel_full,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pel_count
);

  typedef enum logic [1:0] {
    IDLE,
    SIZE,
    PELS,
    DONE
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [SIZE_W-1:0]   n_q;
  logic [FRAMES_W-1:0] f_q;
  logic [DATA_W-1:0]   seed_q;
  logic [SIZE_W-1:0]   row;
  logic [SIZE_W-1:0]   col;
  logic [FRAMES_W-1:0] frame;

  logic                last_col;
  logic                last_row;
  logic                last_frame;
  logic [SIZE_W-1:0]   nrow;
  logic [SIZE_W-1:0]   ncol;
  logic                par;
  logic [DATA_W-1:0]   first_val;
  logic [DATA_W-1:0]   next_val;

  assign out_size_wr = (state == SIZE) & ~out_size_full;
  assign out_pel_wr  = (state == PELS) & ~out_pel_full;

  assign last_col   = col == n_q - SIZE_W'(1);
  assign last_row   = row == n_q - SIZE_W'(1);
  assign last_frame = frame == f_q - FRAMES_W'(1);
  assign ncol       = last_col ? '0 : col + SIZE_W'(1);
  assign nrow       = last_col ? row + SIZE_W'(1) : row;
  assign par        = nrow[0] ^ ncol[0];

  // Value of pel (0,0) for the frame about to start.
  always_comb begin
    first_val = DATA_W'(1);
    unique case (1'b1)
      mode_q == 2'd1: first_val = seed_q;
      mode_q == 2'd2: first_val = seed_q;
      mode_q == 2'd3: first_val = DATA_W'(1) + DATA_W'(frame);
      default: ;
    endcase
  end

  // Value of the following pel; ramps advance a running accumulator.
  always_comb begin
    next_val = out_pel_data + DATA_W'(1);
    unique case (1'b1)
      mode_q == 2'd1: next_val = seed_q;
      mode_q == 2'd2: next_val = par ? ~seed_q : seed_q;
      default: ;
    endcase
  end

  // Sequencer: walks frames, rows and columns; all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mode_q        <= '0;
      n_q           <= '0;
      f_q           <= '0;
      seed_q        <= '0;
      row           <= '0;
      col           <= '0;
      frame         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_size_data <= '0;
      out_pel_data  <= '0;
      pel_count     <= '0;
    end else begin
      done <= 1'b0;
      if (out_pel_wr) pel_count <= pel_count + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (start && cfg_size != '0 && cfg_frames != '0) begin
            mode_q        <= mode;
            n_q           <= cfg_size;
            f_q           <= cfg_frames;
            seed_q        <= cfg_seed;
            frame         <= '0;
            row           <= '0;
            col           <= '0;
            busy          <= 1'b1;
            out_size_data <= cfg_size;
            state         <= SIZE;
          end
        end
        SIZE: begin
          if (out_size_wr) begin
            row          <= '0;
            col          <= '0;
            out_pel_data <= first_val;
            state        <= PELS;
          end
        end
        PELS: begin
          if (out_pel_wr) begin
            row          <= nrow;
            col          <= ncol;
            out_pel_data <= next_val;
            if (last_col && last_row) begin
              if (last_frame) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                frame <= frame + FRAMES_W'(1);
                state <= SIZE;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
